// File: rtl/lemming_world.sv
// rtl/lemming_world.sv - 1-D lemming environment: walls, pit, diggable column, fall/splat tracking
// Optional bump counter output enabled by LEMMING_WORLD_BUMP_CNT_EN.
module lemming_world #(
  parameter int TRACK_LEN  = 16,
  parameter int POS_W      = 4,
  parameter int DEPTH_W    = 3,
  parameter int INIT_X     = 4,
  parameter int HOLE_X     = 8,
  parameter int PIT_DEPTH  = 4,
  parameter int MAX_DEPTH  = 7,
  parameter int DIG_CYCLES = 3,
  parameter int FALL_LIMIT = 20
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               walk_left,
  input  logic               walk_right,
  input  logic               aaah,
  input  logic               digging,
  input  logic               step_en,
  input  logic               dig_req,
  output logic               bump_left,
  output logic               bump_right,
  output logic               ground,
  output logic               dig,
  output logic [POS_W-1:0]   pos_x,
  output logic [DEPTH_W-1:0] depth,
  output logic [4:0]         fall_cnt,
  output logic               splat
`ifdef LEMMING_WORLD_BUMP_CNT_EN
  ,
  output logic [7:0]         bump_count
`endif
);
  localparam int                 CNT_W    = $clog2(DIG_CYCLES + 1);
  localparam logic [DEPTH_W-1:0] MAX_D    = DEPTH_W'(MAX_DEPTH);
  localparam logic [POS_W-1:0]   LAST_X   = POS_W'(TRACK_LEN - 1);
  localparam logic [CNT_W-1:0]   DIG_LAST = CNT_W'(DIG_CYCLES - 1);

  logic [POS_W-1:0]   pos_q, pos_d, dug_x_q, dug_x_d;
  logic [DEPTH_W-1:0] depth_q, depth_d, dug_depth_q, dug_depth_d;
  logic [CNT_W-1:0]   dig_cnt_q, dig_cnt_d;
  logic               dug_valid_q, dug_valid_d;
  logic               bump_l_q, bump_l_d, bump_r_q, bump_r_d;
  logic               dig_q, splat_q, splat_d;
  logic [4:0]         fall_q, fall_d;
  logic [DEPTH_W-1:0] floor_cur, floor_l, floor_r;

  // The single dug column shadows the pit if both happen to coincide.
  function automatic logic [DEPTH_W-1:0] floor_at(input logic [POS_W-1:0]   x,
                                                  input logic               dv,
                                                  input logic [POS_W-1:0]   dx,
                                                  input logic [DEPTH_W-1:0] dd);
    if (dv && x == dx)                return dd;
    else if (x == POS_W'(HOLE_X))     return DEPTH_W'(PIT_DEPTH);
    else                              return '0;
  endfunction

  always_comb begin
    floor_cur = floor_at(pos_q, dug_valid_q, dug_x_q, dug_depth_q);
    floor_l   = floor_at(pos_q - POS_W'(1), dug_valid_q, dug_x_q, dug_depth_q);
    floor_r   = floor_at(pos_q + POS_W'(1), dug_valid_q, dug_x_q, dug_depth_q);
  end

  assign ground = depth_q >= floor_cur;

  always_comb begin
    pos_d       = pos_q;
    depth_d     = depth_q;
    dig_cnt_d   = dig_cnt_q;
    dug_valid_d = dug_valid_q;
    dug_x_d     = dug_x_q;
    dug_depth_d = dug_depth_q;
    bump_l_d    = 1'b0;
    bump_r_d    = 1'b0;
    if (step_en) begin
      if (!ground) begin
        if (depth_q < MAX_D) depth_d = depth_q + DEPTH_W'(1);
        dig_cnt_d = '0;
      end else if (digging) begin
        if (floor_cur >= MAX_D) begin
          if (dig_cnt_q != DIG_LAST) dig_cnt_d = dig_cnt_q + CNT_W'(1);
        end else if (dig_cnt_q == DIG_LAST) begin
          dug_valid_d = 1'b1;
          dug_x_d     = pos_q;
          dug_depth_d = floor_cur + DEPTH_W'(1);
          dig_cnt_d   = '0;
        end else begin
          dig_cnt_d = dig_cnt_q + CNT_W'(1);
        end
      end else if (walk_left) begin
        dig_cnt_d = '0;
        if (pos_q == '0) bump_l_d = 1'b1;
        else begin
          pos_d = pos_q - POS_W'(1);
          if (floor_l < depth_q) depth_d = floor_l;
        end
      end else if (walk_right) begin
        dig_cnt_d = '0;
        if (pos_q == LAST_X) bump_r_d = 1'b1;
        else begin
          pos_d = pos_q + POS_W'(1);
          if (floor_r < depth_q) depth_d = floor_r;
        end
      end else begin
        dig_cnt_d = '0;
      end
    end
  end

  always_comb begin
    fall_d  = aaah ? ((fall_q == 5'd31) ? fall_q : fall_q + 5'd1) : 5'd0;
    splat_d = splat_q | (aaah & ground & (fall_q >= 5'(FALL_LIMIT)));
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      pos_q       <= POS_W'(INIT_X);
      depth_q     <= '0;
      dig_cnt_q   <= '0;
      dug_valid_q <= 1'b0;
      dug_x_q     <= '0;
      dug_depth_q <= '0;
      bump_l_q    <= 1'b0;
      bump_r_q    <= 1'b0;
      dig_q       <= 1'b0;
      fall_q      <= '0;
      splat_q     <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      depth_q     <= depth_d;
      dig_cnt_q   <= dig_cnt_d;
      dug_valid_q <= dug_valid_d;
      dug_x_q     <= dug_x_d;
      dug_depth_q <= dug_depth_d;
      bump_l_q    <= bump_l_d;
      bump_r_q    <= bump_r_d;
      dig_q       <= dig_req;
      fall_q      <= fall_d;
      splat_q     <= splat_d;
    end
  end

`ifdef LEMMING_WORLD_BUMP_CNT_EN
  logic [7:0] bump_cnt_q, bump_cnt_d;

  always_comb begin
    bump_cnt_d = bump_cnt_q;
    if ((bump_l_d | bump_r_d) && bump_cnt_q != 8'hff) bump_cnt_d = bump_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) bump_cnt_q <= '0;
    else           bump_cnt_q <= bump_cnt_d;
  end

  assign bump_count = bump_cnt_q;
`endif

  assign bump_left  = bump_l_q;
  assign bump_right = bump_r_q;
  assign dig        = dig_q;
  assign pos_x      = pos_q;
  assign depth      = depth_q;
  assign fall_cnt   = fall_q;
  assign splat      = splat_q;

endmodule

// File: tb/tb_lemming_world.sv
// tb/tb_lemming_world.sv - self-checking bench for lemming_world
module tb_lemming_world;
  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       walk_left = 1'b0, walk_right = 1'b0, aaah = 1'b0, digging = 1'b0;
  logic       step_en = 1'b0, dig_req = 1'b0;
  logic       bump_left, bump_right, ground, dig, splat;
  logic [3:0] pos_x;
  logic [2:0] depth;
  logic [4:0] fall_cnt;
`ifdef LEMMING_WORLD_BUMP_CNT_EN
  logic [7:0] bump_count;
`endif

  lemming_world dut (
    .clk(clk), .areset_n(areset_n), .walk_left(walk_left), .walk_right(walk_right),
    .aaah(aaah), .digging(digging), .step_en(step_en), .dig_req(dig_req),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground), .dig(dig),
    .pos_x(pos_x), .depth(depth), .fall_cnt(fall_cnt), .splat(splat)
`ifdef LEMMING_WORLD_BUMP_CNT_EN
    , .bump_count(bump_count)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference world: an explicit floor map per column plus lemming state.
  int m_fl[16];
  int m_dug, m_pos, m_depth, m_cnt, m_fall, m_bcnt;
  bit m_bl, m_br, m_dig, m_splat;

  typedef struct {
    bit wl, wr, dg, st, dr;
    int pos, dep;
    bit gnd, bl, br, dgo;
  } vec_t;
  vec_t tbl[10];

  function automatic vec_t mk(bit wl, bit wr, bit dg, bit st, bit dr,
                              int pos, int dep, bit gnd, bit bl, bit br, bit dgo);
    vec_t v;
    v.wl = wl; v.wr = wr; v.dg = dg; v.st = st; v.dr = dr;
    v.pos = pos; v.dep = dep; v.gnd = gnd; v.bl = bl; v.br = br; v.dgo = dgo;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int def_floor(int x);
    return (x == 8) ? 4 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_fl[i] = def_floor(i);
    m_dug = -1; m_pos = 4; m_depth = 0; m_cnt = 0; m_fall = 0; m_bcnt = 0;
    m_bl = 0; m_br = 0; m_dig = 0; m_splat = 0;
  endtask

  task automatic model_step();
    bit g;
    int nx, nf;
    g = (m_depth >= m_fl[m_pos]);
    m_splat = m_splat | (aaah && g && m_fall >= 20);
    m_fall  = aaah ? ((m_fall < 31) ? m_fall + 1 : 31) : 0;
    m_dig   = dig_req;
    m_bl = 0; m_br = 0;
    if (step_en) begin
      if (!g) begin
        if (m_depth < 7) m_depth++;
        m_cnt = 0;
      end else if (digging) begin
        if (m_fl[m_pos] < 7) begin
          m_cnt++;
          if (m_cnt == 3) begin
            nf = m_fl[m_pos] + 1;
            if (m_dug >= 0) m_fl[m_dug] = def_floor(m_dug);
            m_fl[m_pos] = nf;
            m_dug = m_pos;
            m_cnt = 0;
          end
        end
      end else if (walk_left || walk_right) begin
        m_cnt = 0;
        nx = walk_left ? m_pos - 1 : m_pos + 1;
        if (nx < 0) m_bl = 1;
        else if (nx > 15) m_br = 1;
        else begin
          m_pos = nx;
          if (m_fl[nx] < m_depth) m_depth = m_fl[nx];
        end
      end else begin
        m_cnt = 0;
      end
    end
    if ((m_bl || m_br) && m_bcnt < 255) m_bcnt++;
  endtask

  task automatic check_model();
    check("m_pos_x", pos_x, m_pos);
    check("m_depth", depth, m_depth);
    check("m_ground", ground, m_depth >= m_fl[m_pos]);
    check("m_bump_left", bump_left, m_bl);
    check("m_bump_right", bump_right, m_br);
    check("m_dig", dig, m_dig);
    check("m_fall_cnt", fall_cnt, m_fall);
    check("m_splat", splat, m_splat);
`ifdef LEMMING_WORLD_BUMP_CNT_EN
    check("m_bump_count", bump_count, m_bcnt);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Lemming-side aaah is registered: it follows !ground one clock late.
  task automatic lemming_tick();
    bit nxt;
    nxt = !ground;
    tick();
    aaah = nxt;
  endtask

  task automatic clear_inputs();
    walk_left = 0; walk_right = 0; aaah = 0; digging = 0; step_en = 0; dig_req = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset_n = 0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    areset_n = 1;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_pos_x"}, pos_x, 4);
    check({tag, "_depth"}, depth, 0);
    check({tag, "_ground"}, ground, 1);
    check({tag, "_bump_left"}, bump_left, 0);
    check({tag, "_bump_right"}, bump_right, 0);
    check({tag, "_dig"}, dig, 0);
    check({tag, "_fall_cnt"}, fall_cnt, 0);
    check({tag, "_splat"}, splat, 0);
`ifdef LEMMING_WORLD_BUMP_CNT_EN
    check({tag, "_bump_count"}, bump_count, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;

    model_reset();
    do_reset();
    check_reset_values("reset");

    tbl[0] = mk(1, 0, 0, 1, 0, 3, 0, 1, 0, 0, 0);
    tbl[1] = mk(1, 0, 0, 1, 0, 2, 0, 1, 0, 0, 0);
    tbl[2] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    tbl[3] = mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[4] = mk(1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    tbl[5] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);
    tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[7] = mk(1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    tbl[8] = mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    tbl[9] = mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      walk_left = tbl[i].wl; walk_right = tbl[i].wr; digging = tbl[i].dg;
      step_en = tbl[i].st; dig_req = tbl[i].dr;
      tick();
      check($sformatf("vec%0d_pos_x", i), pos_x, tbl[i].pos);
      check($sformatf("vec%0d_depth", i), depth, tbl[i].dep);
      check($sformatf("vec%0d_ground", i), ground, tbl[i].gnd);
      check($sformatf("vec%0d_bump_left", i), bump_left, tbl[i].bl);
      check($sformatf("vec%0d_bump_right", i), bump_right, tbl[i].br);
      check($sformatf("vec%0d_dig", i), dig, tbl[i].dgo);
    end

    // Pit fall with a step every cycle: short fall, safe landing.
    do_reset();
    walk_right = 1; step_en = 1;
    repeat (4) lemming_tick();
    walk_right = 0;
    check("pit_pos_x", pos_x, 8);
    check("pit_ground", ground, 0);
    for (int k = 1; k <= 4; k++) begin
      lemming_tick();
      check("pit_depth", depth, k);
      check("pit_ground_during_fall", ground, (k == 4) ? 1 : 0);
    end
    lemming_tick();
    check("pit_fall_cnt", fall_cnt, 4);
    check("pit_splat", splat, 0);

    // Pit fall with sparse steps: long fall, fatal landing.
    do_reset();
    walk_right = 1; step_en = 1;
    repeat (4) lemming_tick();
    walk_right = 0;
    cyc = 0;
    while (!ground && cyc < 200) begin
      step_en = (cyc % 8 == 7);
      lemming_tick();
      cyc++;
    end
    check("slow_landed", ground, 1);
    check("slow_depth", depth, 4);
    check("slow_fall_ge_limit", (fall_cnt >= 20) ? 1 : 0, 1);
    step_en = 0;
    lemming_tick();
    check("slow_splat", splat, 1);
    step_en = 1;
    repeat (10) begin
      lemming_tick();
      check("slow_splat_sticky", splat, 1);
    end

    // Dig down to bedrock at x=2.
    do_reset();
    walk_left = 1; step_en = 1;
    repeat (2) tick();
    walk_left = 0;
    check("dig_start_pos", pos_x, 2);
    digging = 1;
    for (int lvl = 1; lvl <= 7; lvl++) begin
      repeat (3) tick();
      check($sformatf("dig%0d_ground_drop", lvl), ground, 0);
      check($sformatf("dig%0d_depth_before", lvl), depth, lvl - 1);
      tick();
      check($sformatf("dig%0d_depth", lvl), depth, lvl);
      check($sformatf("dig%0d_ground", lvl), ground, 1);
    end
    repeat (6) tick();
    check("bedrock_depth", depth, 7);
    check("bedrock_ground", ground, 1);
    digging = 0; walk_right = 1;
    tick();
    check("climb_out_pos", pos_x, 3);
    check("climb_out_depth", depth, 0);
    walk_right = 0;

    // Asynchronous reset mid-fall.
    do_reset();
    walk_right = 1; step_en = 1;
    repeat (4) lemming_tick();
    walk_right = 0; dig_req = 1;
    repeat (3) lemming_tick();
    check("midfall_depth", depth, 3);
    check("midfall_dig", dig, 1);
    #2;
    areset_n = 0;
    model_reset();
    #1;
    check_reset_values("async_fall");
    @(negedge clk);
    clear_inputs();
    areset_n = 1;

    // Asynchronous reset mid-dig discards the dug column.
    digging = 1; step_en = 1;
    repeat (3) tick();
    check("middig_ground", ground, 0);
    #2;
    areset_n = 0;
    model_reset();
    #1;
    check_reset_values("async_dig");
    @(negedge clk);
    clear_inputs();
    areset_n = 1;

    // Random walk against the reference world.
    for (int c = 0; c < 4000; c++) begin
      if (c % 700 == 699) do_reset();
      walk_left  = ($urandom % 4 == 0);
      walk_right = ($urandom % 3 == 0);
      digging    = ($urandom % 3 == 0);
      step_en    = $urandom % 2;
      dig_req    = $urandom % 2;
      aaah       = ((c / 48) % 3 == 0) ? 1'b1 : 1'($urandom % 2);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lemming_world.md
Name: lemming_world

Overview:
- Cycle-level environment model that drives the lemming FSM's sensor inputs from its walk/fall/dig outputs.
- Sits opposite the lemming controller in the bench hierarchy and closes the loop.
- Models a 1-D track with end walls, one fixed pit and one diggable column.
- Produces `bump_left`, `bump_right`, `ground` and `dig`, plus position, depth and landing-health status.

Parameters:
- TRACK_LEN, 16: number of track columns; x ranges 0..TRACK_LEN-1, walls beyond both ends.
- POS_W, 4: width of `pos_x`; must satisfy 2^POS_W >= TRACK_LEN.
- DEPTH_W, 3: width of `depth`.
- INIT_X, 4: column the lemming occupies after reset.
- HOLE_X, 8: column of the fixed pit.
- PIT_DEPTH, 4: floor depth of the fixed pit.
- MAX_DEPTH, 7: bedrock depth; no floor is ever deeper than this.
- DIG_CYCLES, 3: consecutive digging steps needed to lower a floor by 1.
- FALL_LIMIT, 20: fall cycles at or above which a landing is fatal.

Ports:
- clk  in  1  clock, rising edge
- areset_n  in  1  asynchronous active-low reset
- walk_left  in  1  from lemming
- walk_right  in  1  from lemming
- aaah  in  1  from lemming
- digging  in  1  from lemming
- step_en  in  1  world advances one step in this cycle
- dig_req  in  1  bench request to issue a dig command
- bump_left  out  1  registered one-cycle pulse
- bump_right  out  1  registered one-cycle pulse
- ground  out  1  combinational: depth >= floor(pos_x)
- dig  out  1  registered one-cycle pulse
- pos_x  out  POS_W  current column
- depth  out  DEPTH_W  current depth; 0 = surface
- fall_cnt  out  5  clock cycles spent with aaah high, saturating
- splat  out  1  sticky fatal-landing flag

Behaviour:
- Reset (asynchronous, while areset_n=0):
  - pos_x=INIT_X, depth=0.
  - bump_left=0, bump_right=0, dig=0, fall_cnt=0, splat=0.
  - dig_cnt=0, dug_valid=0, dug_x=0, dug_depth=0.
- floor(x) is selected in this order:
  - dug_valid && x==dug_x: dug_depth.
  - else x==HOLE_X: PIT_DEPTH.
  - else 0.
- `dig` is asserted exactly one cycle after `dig_req`; dig_req held high gives dig high continuously.
- Bump pulses default to 0 every cycle. They are set only in the cycle following a qualifying step.
- Each step (step_en=1) takes the first matching case:
  - F1 (!ground): depth <= depth+1, clamped at MAX_DEPTH. pos_x unchanged. dig_cnt<=0.
  - F2 (ground && digging):
    - dig_cnt increments.
    - When dig_cnt==DIG_CYCLES-1 and floor(pos_x)<MAX_DEPTH: dug_x<=pos_x, dug_depth<=floor(pos_x)+1, dug_valid<=1, dig_cnt<=0. ground then drops.
    - At MAX_DEPTH (bedrock): dig_cnt saturates and there is no floor change.
  - F3 (ground && walk_left):
    - If pos_x==0: bump_left<=1.
    - Else: pos_x-1, with depth<=floor(new x) when floor(new x)<depth (climbing out to the shallower floor).
    - dig_cnt<=0.
  - F4 (ground && walk_right): mirror of F3 against TRACK_LEN-1, using bump_right. dig_cnt<=0.
  - F5 (none of the above): dig_cnt<=0.
- Walking into a column with a deeper floor leaves ground=0, so the lemming falls on the next steps.
- Digging a new column overwrites dug_x/dug_depth; the old column reverts to its default floor. Only one dug column is ever tracked.
- fall_cnt, evaluated every clock independent of step_en:
  - aaah=1: increment, saturating at 31.
  - aaah=0: clear to 0.
- splat is set when aaah=1 and ground=1 and fall_cnt>=FALL_LIMIT. It stays set until reset.
- walk_left and walk_right both high is treated as walk_left.
- Reset mid-fall or mid-dig restores all state immediately, and the dug column is lost.

Optional Feature:
- Macro: LEMMING_WORLD_BUMP_CNT_EN.
- When defined:
  - Adds output port `bump_count` [7:0].
  - Increments when either bump pulse is set; both set in the same cycle counts +1.
  - Saturates at 255 and resets to 0.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, walk_left=1, step_en=1 every cycle, ground input path observed:
  - pos_x goes 4,3,2,1,0.
  - On the next step, bump_left pulses exactly 1 cycle and pos_x stays 0.
- Walk right from x=4 into x=8, steps every cycle, aaah driven from !ground:
  - ground=0 at x=8.
  - depth climbs 1..4, ground=1 at depth 4.
  - fall_cnt ends at 4 and splat=0.
- As the previous case, but step_en=1 only every 8th cycle:
  - fall_cnt reaches >=20 before depth hits 4.
  - splat=1 on landing and stays 1 through further steps.
- At x=2, digging=1 with step_en every cycle:
  - After 3 steps ground=0 and depth becomes 1, then ground=1.
  - Repeat until depth=7.
  - Further dig steps leave depth=7 and ground=1.
- dig_req pulses in cycle N -> dig high only in cycle N+1.
- areset_n low while depth=3 and falling:
  - All outputs immediately reset, pos_x=4, depth=0, ground=1.
  - With LEMMING_WORLD_BUMP_CNT_EN defined, bump_count=0.
